alu_seq_mdu: RTL and testbench
==============================

Name: alu_seq_mdu

Overview:
- Parametrised, handshaked successor to the combinational core ALU for the ARMv7-M datapath.
- Executes the base op set (ADD/SUB/AND/ORR/EOR/LSL/LSR/ASR) in one cycle.
- Adds iterative multi-cycle MUL, UDIV and SDIV, and produces NZCV flags plus a flag-update mask.
- Sits in the execute stage between operand fetch and writeback; valid/ready on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 8..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  opcode: 0-7 as the base alu_op_t encoding; 8=MUL, 9=UDIV, 10=SDIV; 11-15 reserved.
- a  in  WIDTH  operand A (dividend / multiplicand).
- b  in  WIDTH  operand B (divisor / multiplier / shift amount in b[7:0]).
- c_in  in  1  current C flag, used as shifter carry when the shift amount is 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- flags  out  4  {n,z,c,v}, alu_flags_t packing.
- flags_mask  out  4  {n,z,c,v}; 1 = that flag is architecturally updated by this op.
- div_by_zero  out  1  UDIV/SDIV with b==0; qualified by out_valid.

Behaviour:
- Reset: state=IDLE. in_ready=1, out_valid=0, result=0, flags=0, flags_mask=0, div_by_zero=0, counter=0. Reset mid-operation aborts the op; no result is produced.
- FSM states:
  - IDLE: in_ready=1. Accept when in_valid&in_ready. Ops 0-7 and reserved go to DONE. Ops 8-10 go to BUSY with counter=WIDTH.
  - BUSY: one shift-add (MUL) or restoring-divide step per cycle; counter decrements. When counter reaches 1, go to DONE next cycle. in_ready=0.
  - DONE: out_valid=1; outputs held stable. On out_ready, go to IDLE.
  - No accept in DONE: a new request can be accepted no earlier than the cycle after the handshake.
- Latency (accept edge to first out_valid cycle): 1 cycle for ops 0-7; WIDTH+1 cycles for ops 8-10. Throughput: ops 0-7 = one per 2 cycles minimum.
- Operands and op are captured on accept; input changes afterwards are ignored.
- ADD/SUB:
  - Full WIDTH-bit arithmetic.
  - C = carry out (SUB: C=1 when no borrow, i.e. a>=b unsigned).
  - V = signed overflow. mask=1111.
- AND/ORR/EOR: N, Z from result; C=0, V=0. mask=1100.
- Shifts: amount = b[7:0].
  - Amount 0: result=a, C=c_in.
  - LSL 1..WIDTH: C = last bit shifted out. LSL > WIDTH: result 0, C=0.
  - LSR: same rules as LSL.
  - ASR >= WIDTH: result = all sign bits, C=a[WIDTH-1].
  - mask=1110, V=0.
- MUL: result = low WIDTH bits of a*b (sign-agnostic). N, Z from result. mask=1100.
- UDIV: quotient of unsigned a/b, truncated.
- SDIV:
  - Divide magnitudes; negate the quotient when the signs differ (round toward zero).
  - Most-negative / -1 returns most-negative; no flag set.
- Division by zero: result=0, div_by_zero=1, still takes WIDTH+1 cycles. DIV mask=0000.
- Reserved op: result=0, flags=0, mask=0000, 1-cycle latency.
- Z = (result==0), N = result[WIDTH-1] whenever computed.
- out_valid held with out_ready=0 for any number of cycles: result, flags, mask and div_by_zero are stable.

Test Plan (WIDTH=32):
- ADD a=0x7FFFFFFF, b=1 -> result 0x80000000, flags {1,0,0,1}, mask 1111, out_valid 1 cycle after accept.
- SUB a=5, b=5 -> result 0, flags {0,1,1,0}. Then LSL a=0x80000001, b=1 -> result 0x00000002, C=1, mask 1110.
- LSR b=0 with c_in=1 -> result=a, C=1. ASR a=0x80000000, b=40 -> 0xFFFFFFFF, C=1.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> result 1, N=0, Z=0, out_valid exactly 33 cycles after accept, in_ready=0 throughout BUSY.
- SDIV a=-7, b=2 -> 0xFFFFFFFD. SDIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. UDIV 100/0 -> result 0, div_by_zero=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after a result: outputs stable, in_valid ignored.
  - Assert rst at BUSY counter=10: next cycle in_ready=1, out_valid=0, no stale result.

Source files
------------

// File: rtl/alu_seq_mdu.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_mdu
// Brief    : Handshaked execute-stage ALU. Base ops (ADD/SUB/AND/ORR/EOR/
//            LSL/LSR/ASR) complete in one cycle; MUL, UDIV and SDIV iterate
//            one bit per cycle. Produces NZCV flags plus a flag-update mask.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [3:0]       flags_mask,
    output logic             div_by_zero
);

    // Opcode encoding; 0-7 match the legacy combinational ALU.
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_ORR  = 4'd3;
    localparam logic [3:0] c_OP_EOR  = 4'd4;
    localparam logic [3:0] c_OP_LSL  = 4'd5;
    localparam logic [3:0] c_OP_LSR  = 4'd6;
    localparam logic [3:0] c_OP_ASR  = 4'd7;
    localparam logic [3:0] c_OP_MUL  = 4'd8;
    localparam logic [3:0] c_OP_UDIV = 4'd9;
    localparam logic [3:0] c_OP_SDIV = 4'd10;

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    // MUL : r_acc = partial product, r_opa = multiplicand, r_opb = multiplier
    // DIV : r_acc = partial remainder, r_opa = dividend/quotient, r_opb = divisor
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_mul;
    logic               r_neg;
    logic               r_dbz;

    // ------------------------------------------------------------------
    // Single-cycle datapath (operates directly on the request inputs)
    // ------------------------------------------------------------------
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [7:0]         w_amt;
    logic [7:0]         w_amt_asr;
    logic [WIDTH:0]     w_lsl;
    logic [WIDTH:0]     w_lsr;
    logic [WIDTH:0]     w_asr;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [3:0]         w_mask;
    logic               w_base;
    logic [3:0]         w_flags;

    assign w_sum = {1'b0, a} + {1'b0, b};
    // SUB as a + ~b + 1 so bit WIDTH is the ARM-style "no borrow" carry.
    assign w_dif = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    assign w_amt     = b[7:0];
    assign w_amt_asr = (w_amt >= 8'(WIDTH)) ? 8'(WIDTH) : w_amt;

    // One guard bit beside the operand catches the last bit shifted out;
    // amounts beyond WIDTH naturally flush both result and carry to zero.
    assign w_lsl = {1'b0, a} << w_amt;
    assign w_lsr = {a, 1'b0} >> w_amt;
    assign w_asr = $signed({a, 1'b0}) >>> w_amt_asr;

    // Base-op result, carry, overflow and update mask
    always_comb begin
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_mask = 4'b0000;
        case (op)
            c_OP_ADD: begin
                w_res  = w_sum[MSB:0];
                w_c    = w_sum[WIDTH];
                w_v    = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
                w_mask = 4'b1111;
            end
            c_OP_SUB: begin
                w_res  = w_dif[MSB:0];
                w_c    = w_dif[WIDTH];
                w_v    = (a[MSB] != b[MSB]) && (w_dif[MSB] != a[MSB]);
                w_mask = 4'b1111;
            end
            c_OP_AND: begin
                w_res  = a & b;
                w_mask = 4'b1100;
            end
            c_OP_ORR: begin
                w_res  = a | b;
                w_mask = 4'b1100;
            end
            c_OP_EOR: begin
                w_res  = a ^ b;
                w_mask = 4'b1100;
            end
            c_OP_LSL: begin
                w_res  = (w_amt == 8'd0) ? a    : w_lsl[MSB:0];
                w_c    = (w_amt == 8'd0) ? c_in : w_lsl[WIDTH];
                w_mask = 4'b1110;
            end
            c_OP_LSR: begin
                w_res  = (w_amt == 8'd0) ? a    : w_lsr[WIDTH:1];
                w_c    = (w_amt == 8'd0) ? c_in : w_lsr[0];
                w_mask = 4'b1110;
            end
            c_OP_ASR: begin
                w_res  = (w_amt == 8'd0) ? a    : w_asr[WIDTH:1];
                w_c    = (w_amt == 8'd0) ? c_in : w_asr[0];
                w_mask = 4'b1110;
            end
            default: begin
                w_res  = '0;
                w_c    = 1'b0;
                w_v    = 1'b0;
                w_mask = 4'b0000;
            end
        endcase
    end

    // Reserved opcodes report all-zero flags, so N/Z are gated to base ops.
    assign w_base  = ~op[3];
    assign w_flags = {w_base & w_res[MSB], w_base & (w_res == '0), w_c, w_v};

    // ------------------------------------------------------------------
    // Iterative multiply / divide step
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH-1:0]   w_rem_sh;
    logic               w_sub_ok;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_q;
    logic [WIDTH-1:0]   w_div_res;
    logic [WIDTH-1:0]   w_mdu_res;
    logic [3:0]         w_mdu_flags;

    assign w_mul_acc = r_acc + (r_opb[0] ? r_opa : '0);

    // Restoring division: the partial remainder is always below the divisor,
    // so a set top bit before the shift guarantees the subtraction succeeds,
    // and WIDTH bits are enough to hold the true post-subtract remainder.
    assign w_rem_sh  = {r_acc[MSB-1:0], r_opa[MSB]};
    assign w_sub_ok  = r_acc[MSB] | (w_rem_sh >= r_opb);
    assign w_div_rem = w_sub_ok ? (w_rem_sh - r_opb) : w_rem_sh;
    assign w_div_q   = {r_opa[MSB-1:0], w_sub_ok};

    // Most-negative / -1 falls out naturally: the magnitude quotient is
    // 2^(WIDTH-1) and its two's-complement negation wraps to itself.
    assign w_div_res = r_dbz ? '0 : (r_neg ? (-w_div_q) : w_div_q);
    assign w_mdu_res = r_is_mul ? w_mul_acc : w_div_res;
    assign w_mdu_flags = {w_mdu_res[MSB], (w_mdu_res == '0), 2'b00};

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_is_mul    <= 1'b0;
            r_neg       <= 1'b0;
            r_dbz       <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            flags       <= 4'b0000;
            flags_mask  <= 4'b0000;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if ((op >= c_OP_MUL) && (op <= c_OP_SDIV)) begin
                            r_state  <= S_BUSY;
                            r_cnt    <= CNT_W'(WIDTH);
                            r_acc    <= '0;
                            r_is_mul <= (op == c_OP_MUL);
                            r_dbz    <= (op != c_OP_MUL) && (b == '0);
                            if (op == c_OP_SDIV) begin
                                r_opa <= a[MSB] ? (-a) : a;
                                r_opb <= b[MSB] ? (-b) : b;
                                r_neg <= a[MSB] ^ b[MSB];
                            end else begin
                                r_opa <= a;
                                r_opb <= b;
                                r_neg <= 1'b0;
                            end
                        end else begin
                            r_state     <= S_DONE;
                            out_valid   <= 1'b1;
                            result      <= w_res;
                            flags       <= w_flags;
                            flags_mask  <= w_mask;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_is_mul) begin
                        r_acc <= w_mul_acc;
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                    end else begin
                        r_acc <= w_div_rem;
                        r_opa <= w_div_q;
                    end
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= S_DONE;
                        out_valid   <= 1'b1;
                        result      <= w_mdu_res;
                        flags       <= w_mdu_flags;
                        flags_mask  <= r_is_mul ? 4'b1100 : 4'b0000;
                        div_by_zero <= r_dbz;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_mdu
// Brief    : Self-checking bench for alu_seq_mdu (WIDTH=32) against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_mdu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [3:0]    flags;
    logic [3:0]    flags_mask;
    logic          div_by_zero;

    int total = 0;
    int bad   = 0;

    alu_seq_mdu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .c_in        (c_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags       (flags),
        .flags_mask  (flags_mask),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic from the operation definitions.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, output logic [W-1:0] r, output logic [3:0] f,
                                  output logic [3:0] m, output logic dz);
        longint sx, sy, s;
        longint unsigned ux, uy;
        int n;
        logic n_f, z_f, c_f, v_f;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        n  = int'(y[7:0]);
        r = '0; c_f = 1'b0; v_f = 1'b0; m = 4'b0000; dz = 1'b0;
        case (o)
            4'd0: begin
                r = x + y; c_f = ((ux + uy) > 64'hFFFF_FFFF);
                s = sx + sy; v_f = (longint'($signed(r)) != s); m = 4'b1111;
            end
            4'd1: begin
                r = x - y; c_f = (x >= y);
                s = sx - sy; v_f = (longint'($signed(r)) != s); m = 4'b1111;
            end
            4'd2: begin r = x & y; m = 4'b1100; end
            4'd3: begin r = x | y; m = 4'b1100; end
            4'd4: begin r = x ^ y; m = 4'b1100; end
            4'd5: begin
                m = 4'b1110;
                if (n == 0) begin r = x; c_f = ci; end
                else if (n < W) begin r = x << n; c_f = x[W-n]; end
                else if (n == W) begin r = '0; c_f = x[0]; end
                else begin r = '0; c_f = 1'b0; end
            end
            4'd6: begin
                m = 4'b1110;
                if (n == 0) begin r = x; c_f = ci; end
                else if (n < W) begin r = x >> n; c_f = x[n-1]; end
                else if (n == W) begin r = '0; c_f = x[W-1]; end
                else begin r = '0; c_f = 1'b0; end
            end
            4'd7: begin
                m = 4'b1110;
                if (n == 0) begin r = x; c_f = ci; end
                else if (n < W) begin r = $signed(x) >>> n; c_f = x[n-1]; end
                else begin r = x[W-1] ? '1 : '0; c_f = x[W-1]; end
            end
            4'd8: begin r = W'(ux * uy); m = 4'b1100; end
            4'd9: begin
                if (y == 0) begin r = '0; dz = 1'b1; end
                else r = W'(ux / uy);
            end
            4'd10: begin
                if (y == 0) begin r = '0; dz = 1'b1; end
                else r = W'(sx / sy);
            end
            default: begin r = '0; m = 4'b0000; end
        endcase
        n_f = r[W-1];
        z_f = (r == 0);
        f = (o > 4'd10) ? 4'b0000 : {n_f, z_f, c_f, v_f};
    endfunction

    // Issue one request from IDLE, scramble inputs after accept, wait for the
    // result, sample it and complete the output handshake.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, output logic [W-1:0] r, output logic [3:0] f,
                          output logic [3:0] fm, output logic dz, output int lat,
                          output logic rdy_leak);
        @(negedge clk);
        op = o; a = x; b = y; c_in = ci; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = $urandom; b = $urandom; c_in = 1'($urandom);
        lat = 1; rdy_leak = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) rdy_leak = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        r = result; f = flags; fm = flags_mask; dz = div_by_zero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0; c_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, result, flags, flags_mask, div_by_zero} !== {1'b1, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h f=%b m=%b dz=%b want rdy=1 vld=0 res=0 f=0 m=0 dz=0",
                     in_ready, out_valid, result, flags, flags_mask, div_by_zero);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;
        logic [W-1:0] er;
        logic [3:0]   ef;
        logic [3:0]   em;
        logic         ed;
        int           el;
    } vec_t;

    // Directed vectors with hand-computed expectations
    task automatic test_directed();
        vec_t v[$];
        logic [W-1:0] r; logic [3:0] f, fm; logic dz, leak; int lat;
        logic mdu;
        v.push_back('{4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 4'b1001, 4'b1111, 1'b0, 1});
        v.push_back('{4'd1, 32'd5, 32'd5, 1'b0, 32'd0, 4'b0110, 4'b1111, 1'b0, 1});
        v.push_back('{4'd5, 32'h8000_0001, 32'd1, 1'b0, 32'h0000_0002, 4'b0010, 4'b1110, 1'b0, 1});
        v.push_back('{4'd6, 32'h1234_5678, 32'd0, 1'b1, 32'h1234_5678, 4'b0010, 4'b1110, 1'b0, 1});
        v.push_back('{4'd7, 32'h8000_0000, 32'd40, 1'b0, 32'hFFFF_FFFF, 4'b1010, 4'b1110, 1'b0, 1});
        v.push_back('{4'd5, 32'd1, 32'd33, 1'b1, 32'd0, 4'b0100, 4'b1110, 1'b0, 1});
        v.push_back('{4'd6, 32'h8000_0000, 32'd32, 1'b0, 32'd0, 4'b0110, 4'b1110, 1'b0, 1});
        v.push_back('{4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 32'h0000_00F0, 4'b0000, 4'b1100, 1'b0, 1});
        v.push_back('{4'd13, 32'h1234_0000, 32'h0000_0001, 1'b1, 32'd0, 4'b0000, 4'b0000, 1'b0, 1});
        v.push_back('{4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 4'b0000, 4'b1100, 1'b0, 33});
        v.push_back('{4'd10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 4'b0000, 4'b0000, 1'b0, 33});
        v.push_back('{4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 4'b0000, 4'b0000, 1'b0, 33});
        v.push_back('{4'd9, 32'd100, 32'd0, 1'b0, 32'd0, 4'b0000, 4'b0000, 1'b1, 33});
        foreach (v[i]) begin
            run_op(v[i].o, v[i].x, v[i].y, v[i].ci, r, f, fm, dz, lat, leak);
            mdu = (v[i].o >= 4'd8) && (v[i].o <= 4'd10);
            total++;
            if (r !== v[i].er || fm !== v[i].em || dz !== v[i].ed ||
                (mdu ? ((f & fm) !== (v[i].ef & v[i].em)) : (f !== v[i].ef))) begin
                bad++;
                $display("FAIL directed[%0d] op=%0d: got res=%h f=%b m=%b dz=%b want res=%h f=%b m=%b dz=%b",
                         i, v[i].o, r, f, fm, dz, v[i].er, v[i].ef, v[i].em, v[i].ed);
            end
            total++;
            if (lat !== v[i].el || leak !== 1'b0) begin
                bad++;
                $display("FAIL directed_latency[%0d] op=%0d: got lat=%0d rdy_during_busy=%b want lat=%0d rdy_during_busy=0",
                         i, v[i].o, lat, leak, v[i].el);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [W-1:0] r, er, x, y; logic [3:0] f, fm, ef, em; logic dz, ed, leak, ci; int lat;
        logic [3:0] o;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 7));
            if (i % 10 == 9) o = 4'($urandom_range(11, 15));
            x = $urandom; y = $urandom; ci = 1'($urandom);
            if (o >= 4'd5 && o <= 4'd7 && (i % 3) != 0) y = {24'($urandom), 8'($urandom_range(0, 40))};
            if (i % 7 == 0) y = x;
            model(o, x, y, ci, er, ef, em, ed);
            run_op(o, x, y, ci, r, f, fm, dz, lat, leak);
            total++;
            if (r !== er || f !== ef || fm !== em || dz !== ed || lat !== 1) begin
                bad++;
                $display("FAIL alu_random[%0d] op=%0d a=%h b=%h cin=%b: got res=%h f=%b m=%b dz=%b lat=%0d want res=%h f=%b m=%b dz=%b lat=1",
                         i, o, x, y, ci, r, f, fm, dz, lat, er, ef, em, ed);
            end
        end
    endtask

    task automatic test_mdu_random();
        logic [W-1:0] r, er, x, y; logic [3:0] f, fm, ef, em; logic dz, ed, leak; int lat;
        logic [3:0] o;
        for (int i = 0; i < 15; i++) begin
            o = 4'(8 + $urandom_range(0, 2));
            x = $urandom; y = $urandom;
            if (i % 3 == 0) y = W'($urandom_range(0, 3));
            if (i % 5 == 1) y = -W'($urandom_range(1, 9));
            model(o, x, y, 1'b0, er, ef, em, ed);
            run_op(o, x, y, 1'b0, r, f, fm, dz, lat, leak);
            total++;
            if (r !== er || (f & fm) !== (ef & em) || fm !== em || dz !== ed || lat !== W + 1 || leak !== 1'b0) begin
                bad++;
                $display("FAIL mdu_random[%0d] op=%0d a=%h b=%h: got res=%h f=%b m=%b dz=%b lat=%0d leak=%b want res=%h f=%b m=%b dz=%b lat=%0d leak=0",
                         i, o, x, y, r, f, fm, dz, lat, leak, er, ef, em, ed, W + 1);
            end
        end
    endtask

    // Two-cycle cadence with in_valid and out_ready held high
    task automatic test_back_to_back();
        logic [W-1:0] er, x, y; logic [3:0] ef, em, o; logic ed, ci;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            o = 4'($urandom_range(0, 7)); x = $urandom; y = $urandom; ci = 1'($urandom);
            if (o >= 4'd5) y = W'($urandom_range(0, 35));
            model(o, x, y, ci, er, ef, em, ed);
            op = o; a = x; b = y; c_in = ci; in_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || flags !== ef || flags_mask !== em) begin
                bad++;
                $display("FAIL back_to_back_result[%0d] op=%0d: got vld=%b rdy=%b res=%h f=%b m=%b want vld=1 rdy=0 res=%h f=%b m=%b",
                         i, o, out_valid, in_ready, result, flags, flags_mask, er, ef, em);
            end
            op = 4'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            total++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL back_to_back_idle[%0d]: got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    // Result held under backpressure while a new request is presented
    task automatic test_backpressure();
        logic [W-1:0] er, x, y; logic [3:0] ef, em; logic ed;
        x = $urandom; y = $urandom;
        model(4'd0, x, y, 1'b0, er, ef, em, ed);
        @(negedge clk);
        op = 4'd0; a = x; b = y; c_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        op = 4'd4; a = $urandom; b = $urandom;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== er || flags !== ef ||
                flags_mask !== em || div_by_zero !== ed) begin
                bad++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b res=%h f=%b m=%b dz=%b want vld=1 rdy=0 res=%h f=%b m=%b dz=%b",
                         k, out_valid, in_ready, result, flags, flags_mask, div_by_zero, er, ef, em, ed);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    // Reset in the middle of a multiply must abort it without a result
    task automatic test_reset_mid();
        logic stale;
        @(negedge clk);
        op = 4'd8; a = $urandom; b = $urandom; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (22) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            bad++;
            $display("FAIL reset_mid_busy: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0", in_ready, out_valid, result);
        end
        @(negedge clk); rst = 1'b0;
        stale = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_stale: got out_valid rise=%b want 0", stale);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_alu_random();
        test_mdu_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
